// File: rtl/unified_mem_arb_pkg.sv
// Shared definitions for the unified memory arbiter.
// Holds the FSM state encoding, the port identifiers used for grants and the
// read/write encoding of the we_re field, plus a small grant helper.
package unified_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic GRANT_I  = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  localparam logic WE_READ  = 1'b0;
  localparam logic WE_WRITE = 1'b1;

  // The port that did not win last time; used to break ties.
  function automatic logic other_port(input logic port);
    return (port == GRANT_I) ? GRANT_D : GRANT_I;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin picker (purely combinational).
// Ports:
//   req[1:0]    : request bits, bit 0 = instruction port, bit 1 = data port
//   last_grant  : port granted most recently
//   grant_valid : at least one request is present
//   grant_id    : winning port (GRANT_I / GRANT_D)
module arb_rr2
  import unified_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // Pick the single requester, or on a tie the port not served last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = GRANT_I;
    case (req)
      2'b01: begin
        grant_valid = 1'b1;
        grant_id    = GRANT_I;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_id    = GRANT_D;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_id    = other_port(last_grant);
      end
      default: begin
        grant_valid = 1'b0;
        grant_id    = GRANT_I;
      end
    endcase
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one memory_top between the instruction-fetch and data ports.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP; ISSUE may skip WAIT when the
// memory answers immediately. A stuck memory is released after TIMEOUT_CYCLES
// cycles in WAIT, returning zero data and setting a sticky timeout_err.
// Ports:
//   clk, rst (async, active-low)
//   i_* : instruction port (request/we_re/mask/address/data_in in, valid/data_out out)
//   d_* : data port, same shape as i_*
//   m_* : memory side (request/we_re/mask/address/data_in out, valid/data_out in)
//   busy        : FSM is not in IDLE
//   timeout_err : sticky, set on the first timeout, cleared only by reset
module unified_mem_arbiter
  import unified_mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_request,
  input  logic              i_we_re,
  input  logic [3:0]        i_mask,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_data_in,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_data_out,

  input  logic              d_request,
  input  logic              d_we_re,
  input  logic [3:0]        d_mask,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_data_in,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_data_out,

  output logic              m_request,
  output logic              m_we_re,
  output logic [3:0]        m_mask,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_data_in,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_data_out,

  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_r;
  logic                last_grant_r;
  logic [CNT_W-1:0]    cnt_r;

  logic                lat_we_re_r;
  logic [3:0]          lat_mask_r;
  logic [ADDR_W-1:0]   lat_address_r;
  logic [DATA_W-1:0]   lat_data_in_r;

  logic                m_request_r;
  logic                i_valid_r;
  logic [DATA_W-1:0]   i_data_out_r;
  logic                d_valid_r;
  logic [DATA_W-1:0]   d_data_out_r;
  logic                busy_r;
  logic                timeout_err_r;

  logic                grant_valid_s;
  logic                grant_id_s;

  logic                sel_we_re_s;
  logic [3:0]          sel_mask_s;
  logic [ADDR_W-1:0]   sel_address_s;
  logic [DATA_W-1:0]   sel_data_in_s;

  logic                done_s;
  logic                timeout_hit_s;
  logic [DATA_W-1:0]   done_data_s;

  arb_rr2 u_arb (
    .req         ({d_request, i_request}),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Route the winning port's request fields toward the latches.
  always_comb begin
    sel_we_re_s   = WE_READ;
    sel_mask_s    = 4'h0;
    sel_address_s = '0;
    sel_data_in_s = '0;
    if (grant_id_s == GRANT_I) begin
      sel_we_re_s   = i_we_re;
      sel_mask_s    = i_mask;
      sel_address_s = i_address;
      sel_data_in_s = i_data_in;
    end else begin
      sel_we_re_s   = d_we_re;
      sel_mask_s    = d_mask;
      sel_address_s = d_address;
      sel_data_in_s = d_data_in;
    end
  end

  // Decide whether the current access completes this cycle and with what data.
  // A real m_valid in WAIT wins over a timeout landing in the same cycle.
  always_comb begin
    done_s        = 1'b0;
    timeout_hit_s = 1'b0;
    done_data_s   = '0;
    if ((state_r == ST_ISSUE || state_r == ST_WAIT) && m_valid) begin
      done_s      = 1'b1;
      done_data_s = m_data_out;
    end else if (state_r == ST_WAIT && cnt_r == CNT_LAST) begin
      done_s        = 1'b1;
      timeout_hit_s = 1'b1;
      done_data_s   = '0;
    end else begin
      done_s        = 1'b0;
      timeout_hit_s = 1'b0;
      done_data_s   = '0;
    end
  end

  // Access sequencer: state, grant history, latches, wait counter and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= GRANT_D;
      cnt_r         <= '0;
      lat_we_re_r   <= WE_READ;
      lat_mask_r    <= 4'h0;
      lat_address_r <= '0;
      lat_data_in_r <= '0;
      m_request_r   <= 1'b0;
      i_valid_r     <= 1'b0;
      i_data_out_r  <= '0;
      d_valid_r     <= 1'b0;
      d_data_out_r  <= '0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      // Pulsed outputs default low; only the transitions below raise them.
      m_request_r <= 1'b0;
      i_valid_r   <= 1'b0;
      d_valid_r   <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (grant_valid_s) begin
            state_r       <= ST_ISSUE;
            last_grant_r  <= grant_id_s;
            lat_we_re_r   <= sel_we_re_s;
            lat_mask_r    <= sel_mask_s;
            lat_address_r <= sel_address_s;
            lat_data_in_r <= sel_data_in_s;
            m_request_r   <= 1'b1;
            busy_r        <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase

      // Completion overrides the case above; last_grant_r names the port
      // that owns the access in flight.
      if (done_s) begin
        state_r <= ST_RESP;
        if (last_grant_r == GRANT_I) begin
          i_valid_r    <= 1'b1;
          i_data_out_r <= done_data_s;
        end else begin
          d_valid_r    <= 1'b1;
          d_data_out_r <= done_data_s;
        end
        if (timeout_hit_s) begin
          timeout_err_r <= 1'b1;
        end
      end
    end
  end

  assign m_request   = m_request_r;
  assign m_we_re     = lat_we_re_r;
  assign m_mask      = lat_mask_r;
  assign m_address   = lat_address_r;
  assign m_data_in   = lat_data_in_r;
  assign i_valid     = i_valid_r;
  assign i_data_out  = i_data_out_r;
  assign d_valid     = d_valid_r;
  assign d_data_out  = d_data_out_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

endmodule
